// File: rtl/cmt_pkg.sv
// Shared types and constants for the commit controller: opcodes, CSR
// addresses, controller state and the buffered commit entry.
package cmt_pkg;

  localparam logic [6:0]  OPC_TRAP   = 7'h6b;
  localparam logic [6:0]  OPC_SYSTEM = 7'h73;
  localparam logic [11:0] CSR_MCYCLE = 12'hB00;
  localparam logic [11:0] CSR_CYCLE  = 12'hC00;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } cmt_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [63:0] rd_wdata;
    logic        skip;
    logic        trap;
  } cmt_entry_t;

  // Reads of mcycle/cycle return simulator-dependent values, so they are skipped.
  function automatic logic is_csr_cycle_read(input logic [31:0] inst);
    return (inst[6:0] == OPC_SYSTEM) && (inst[14:12] != 3'd0) &&
           ((inst[31:20] == CSR_MCYCLE) || (inst[31:20] == CSR_CYCLE));
  endfunction

endpackage

// File: rtl/cmt_fifo.sv
// Synchronous FIFO of commit entries with asynchronous reset.
// Push is ignored when full and pop when empty; there is no bypass path.
module cmt_fifo
  import cmt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  cmt_entry_t               push_data,
  input  logic                     pop,
  output cmt_entry_t               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  cmt_entry_t        mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cmt_ctrl.sv
// Commit controller: buffers retiring instructions, issues one commit per
// cycle with a skip flag, and drains then halts after the trap instruction.
module cmt_ctrl
  import cmt_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [63:0] MMIO_LIMIT = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wb_valid,
  output logic        o_wb_ready,
  input  logic [63:0] i_wb_pc,
  input  logic [31:0] i_wb_inst,
  input  logic [4:0]  i_wb_rd,
  input  logic        i_wb_rd_wen,
  input  logic [63:0] i_wb_rd_wdata,
  input  logic        i_wb_mem_en,
  input  logic [63:0] i_wb_mem_addr,
  output logic        o_cmtvalid,
  output logic        o_skipcmt,
  output logic [63:0] o_pc,
  output logic [31:0] o_inst,
  output logic [4:0]  o_rd,
  output logic        o_rd_wen,
  output logic [63:0] o_rd_wdata,
  output logic        o_trap,
  output logic        o_halted,
  output logic [63:0] o_cycle_cnt,
  output logic [63:0] o_instr_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Handshake: a transfer happens at a posedge where i_wb_valid && o_wb_ready;
  // the writeback stage holds its payload stable while ready is low.
  cmt_state_t     state_q;
  cmt_entry_t     push_entry;
  cmt_entry_t     head;
  logic           full;
  logic           empty;
  logic [CW-1:0]  count;
  logic           push;
  logic           pop;
  logic           wb_trap;
  logic [63:0]    cycle_q;

  assign o_wb_ready  = !rst && (state_q == ST_RUN) && (count < DEPTH_C);
  assign push        = i_wb_valid && o_wb_ready && !full;
  assign pop         = !empty && (state_q != ST_HALT);
  assign wb_trap     = (i_wb_inst[6:0] == OPC_TRAP);
  assign o_cycle_cnt = cycle_q;

  always_comb begin
    push_entry          = '0;
    push_entry.pc       = i_wb_pc;
    push_entry.inst     = i_wb_inst;
    push_entry.rd       = i_wb_rd;
    push_entry.rd_wen   = i_wb_rd_wen;
    push_entry.rd_wdata = i_wb_rd_wdata;
    push_entry.skip     = (i_wb_mem_en && (i_wb_mem_addr < MMIO_LIMIT)) ||
                          is_csr_cycle_read(i_wb_inst);
    push_entry.trap     = wb_trap;
  end

  cmt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cycle_q     <= '0;
      o_instr_cnt <= '0;
      o_cmtvalid  <= 1'b0;
      o_skipcmt   <= 1'b0;
      o_pc        <= '0;
      o_inst      <= '0;
      o_rd        <= '0;
      o_rd_wen    <= 1'b0;
      o_rd_wdata  <= '0;
      o_trap      <= 1'b0;
      o_halted    <= 1'b0;
    end else begin
      if (state_q != ST_HALT) cycle_q <= cycle_q + 64'd1;
      o_halted   <= (state_q == ST_HALT);
      o_cmtvalid <= pop;
      o_trap     <= pop && head.trap;
      if (pop) begin
        o_skipcmt   <= head.skip;
        o_pc        <= head.pc;
        o_inst      <= head.inst;
        o_rd        <= head.rd;
        o_rd_wen    <= head.rd_wen;
        o_rd_wdata  <= head.rd_wdata;
        o_instr_cnt <= o_instr_cnt + 64'd1;
      end
      case (state_q)
        ST_RUN:   if (push && wb_trap) state_q <= ST_DRAIN;
        ST_DRAIN: if (pop && head.trap) state_q <= ST_HALT;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmt_ctrl.sv
// Directed bench for cmt_ctrl: latency, streaming, skip decode, trap drain
// and halt, asynchronous reset and cycle counter wrap.
module tb_cmt_ctrl;

  localparam int W = 168;

  logic        clk;
  logic        rst;
  logic        i_wb_valid;
  logic        o_wb_ready;
  logic [63:0] i_wb_pc;
  logic [31:0] i_wb_inst;
  logic [4:0]  i_wb_rd;
  logic        i_wb_rd_wen;
  logic [63:0] i_wb_rd_wdata;
  logic        i_wb_mem_en;
  logic [63:0] i_wb_mem_addr;
  logic        o_cmtvalid;
  logic        o_skipcmt;
  logic [63:0] o_pc;
  logic [31:0] o_inst;
  logic [4:0]  o_rd;
  logic        o_rd_wen;
  logic [63:0] o_rd_wdata;
  logic        o_trap;
  logic        o_halted;
  logic [63:0] o_cycle_cnt;
  logic [63:0] o_instr_cnt;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_e;
  logic [W-1:0] exp_e;
  logic [63:0]  exp_instr = 0;
  int           cur_run = 0;
  int           max_run = 0;
  logic [63:0]  frozen_cyc;

  cmt_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_wb_valid    (i_wb_valid),
    .o_wb_ready    (o_wb_ready),
    .i_wb_pc       (i_wb_pc),
    .i_wb_inst     (i_wb_inst),
    .i_wb_rd       (i_wb_rd),
    .i_wb_rd_wen   (i_wb_rd_wen),
    .i_wb_rd_wdata (i_wb_rd_wdata),
    .i_wb_mem_en   (i_wb_mem_en),
    .i_wb_mem_addr (i_wb_mem_addr),
    .o_cmtvalid    (o_cmtvalid),
    .o_skipcmt     (o_skipcmt),
    .o_pc          (o_pc),
    .o_inst        (o_inst),
    .o_rd          (o_rd),
    .o_rd_wen      (o_rd_wen),
    .o_rd_wdata    (o_rd_wdata),
    .o_trap        (o_trap),
    .o_halted      (o_halted),
    .o_cycle_cnt   (o_cycle_cnt),
    .o_instr_cnt   (o_instr_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: present one instruction at a negedge and hold it until accepted
  task automatic send(input logic [63:0] pc, input logic [31:0] inst, input logic [4:0] rd,
                      input logic wen, input logic [63:0] wdata, input logic mem_en,
                      input logic [63:0] addr, input logic exp_skip);
    int guard = 0;
    logic exp_trap;
    exp_trap      = (inst[6:0] == 7'h6b);
    i_wb_valid    = 1'b1;
    i_wb_pc       = pc;
    i_wb_inst     = inst;
    i_wb_rd       = rd;
    i_wb_rd_wen   = wen;
    i_wb_rd_wdata = wdata;
    i_wb_mem_en   = mem_en;
    i_wb_mem_addr = addr;
    while (!o_wb_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    total++;
    assert (o_wb_ready === 1'b1) else begin
      bad++;
      $error("FAIL send_timeout observed=%0d expected=1 pc=%h", o_wb_ready, pc);
    end
    if (o_wb_ready) begin
      exp_q.push_back({pc, inst, rd, wen, wdata, exp_skip, exp_trap});
      @(posedge clk);
      @(negedge clk);
    end else begin
      i_wb_valid = 1'b0;
    end
  endtask

  task automatic idle();
    i_wb_valid    = 1'b0;
    i_wb_mem_en   = 1'b0;
  endtask

  // scoreboard: every commit must match the head of the expected queue
  always @(negedge clk) begin
    if (o_cmtvalid) begin
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL stray_commit observed pc=%h expected=no_commit", o_pc);
      end
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        obs_e = {o_pc, o_inst, o_rd, o_rd_wen, o_rd_wdata, o_skipcmt, o_trap};
        total++;
        assert (obs_e === exp_e) else begin
          bad++;
          $error("FAIL commit observed=%h expected=%h", obs_e, exp_e);
        end
        exp_instr = exp_instr + 64'd1;
        total++;
        assert (o_instr_cnt === exp_instr) else begin
          bad++;
          $error("FAIL instr_cnt observed=%0d expected=%0d", o_instr_cnt, exp_instr);
        end
      end
    end else begin
      cur_run = 0;
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    i_wb_pc = '0; i_wb_inst = '0; i_wb_rd = '0; i_wb_rd_wen = 1'b0;
    i_wb_rd_wdata = '0; i_wb_mem_addr = '0;
    #1;
    chk("rst_cmtvalid", 64'(o_cmtvalid), 64'd0);
    chk("rst_ready", 64'(o_wb_ready), 64'd0);
    chk("rst_halted", 64'(o_halted), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_ready", 64'(o_wb_ready), 64'd1);
    chk("rel_cycle", o_cycle_cnt, 64'd0);
    chk("rel_instr", o_instr_cnt, 64'd0);
    @(negedge clk);
    chk("cycle_one", o_cycle_cnt, 64'd1);

    // single ALU instruction: commit visible one cycle after the push edge
    send(64'h8000_0000, 32'h0000_0293, 5'd5, 1'b1, 64'h1234, 1'b0, 64'h0, 1'b0);
    idle();
    chk("lat_not_yet", 64'(o_cmtvalid), 64'd0);
    @(negedge clk);
    chk("lat_valid", 64'(o_cmtvalid), 64'd1);
    chk("lat_pc", o_pc, 64'h8000_0000);
    chk("lat_wdata", o_rd_wdata, 64'h1234);
    chk("lat_skip", 64'(o_skipcmt), 64'd0);
    chk("lat_instr", o_instr_cnt, 64'd1);

    // six back-to-back pushes stream out as six consecutive commits
    max_run = 0;
    for (int i = 0; i < 6; i++)
      send(64'h8000_0100 + 64'(4 * i), 32'h0000_0013, 5'(i + 1), 1'b1,
           64'(i * 32'h11), 1'b0, 64'h0, 1'b0);
    idle();
    repeat (4) @(negedge clk);
    chk("stream_run", 64'(max_run), 64'd6);
    chk("stream_drained", 64'(exp_q.size()), 64'd0);

    // skip decode, including MMIO boundary and CSR corner cases
    send(64'h8000_0200, 32'h0000_3503, 5'd10, 1'b1, 64'h1, 1'b1, 64'h0000_0000_0200_0000, 1'b1);
    send(64'h8000_0204, 32'hB000_2573, 5'd10, 1'b1, 64'h2, 1'b0, 64'h0, 1'b1);
    send(64'h8000_0208, 32'h0000_3503, 5'd10, 1'b1, 64'h3, 1'b1, 64'h0000_0000_8000_1000, 1'b0);
    send(64'h8000_020c, 32'h0000_3503, 5'd10, 1'b1, 64'h4, 1'b1, 64'h0000_0000_7FFF_FFFF, 1'b1);
    send(64'h8000_0210, 32'h0000_3503, 5'd10, 1'b1, 64'h5, 1'b1, 64'h0000_0000_8000_0000, 1'b0);
    send(64'h8000_0214, 32'h0000_3503, 5'd10, 1'b1, 64'h6, 1'b1, 64'hFFFF_FFFF_0000_0000, 1'b0);
    send(64'h8000_0218, 32'hC000_2573, 5'd10, 1'b1, 64'h7, 1'b0, 64'h0, 1'b1);
    send(64'h8000_021c, 32'hC000_0073, 5'd0,  1'b0, 64'h8, 1'b0, 64'h0, 1'b0);
    send(64'h8000_0220, 32'hB020_2573, 5'd10, 1'b1, 64'h9, 1'b0, 64'h0, 1'b0);
    send(64'h8000_0224, 32'h0000_0013, 5'd1,  1'b1, 64'hA, 1'b0, 64'h0000_0000_0000_0100, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    chk("skip_drained", 64'(exp_q.size()), 64'd0);

    // trap behind two older entries: drain in order, then halt and freeze
    send(64'h8000_0300, 32'h0000_0013, 5'd1, 1'b1, 64'hA1, 1'b0, 64'h0, 1'b0);
    send(64'h8000_0304, 32'h0000_0013, 5'd2, 1'b1, 64'hB2, 1'b0, 64'h0, 1'b0);
    send(64'h8000_0308, 32'h0000_006b, 5'd0, 1'b0, 64'h0,  1'b0, 64'h0, 1'b0);
    chk("trap_ready_low", 64'(o_wb_ready), 64'd0);
    i_wb_inst = 32'h0000_0013;
    i_wb_pc   = 64'h8000_030c;
    @(negedge clk);
    chk("trap_flag", 64'(o_trap), 64'd1);
    chk("trap_valid", 64'(o_cmtvalid), 64'd1);
    chk("trap_not_halted_yet", 64'(o_halted), 64'd0);
    @(negedge clk);
    chk("halted", 64'(o_halted), 64'd1);
    chk("halt_no_commit", 64'(o_cmtvalid), 64'd0);
    chk("halt_trap_low", 64'(o_trap), 64'd0);
    frozen_cyc = o_cycle_cnt;
    repeat (10) @(negedge clk);
    chk("halt_cycle_frozen", o_cycle_cnt, frozen_cyc);
    chk("halt_ready_low", 64'(o_wb_ready), 64'd0);
    chk("halt_still", 64'(o_halted), 64'd1);
    idle();

    // leave HALT through reset
    rst = 1'b1;
    exp_q.delete();
    exp_instr = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("unhalt_ready", 64'(o_wb_ready), 64'd1);
    chk("unhalt_halted", 64'(o_halted), 64'd0);
    @(negedge clk);

    // asynchronous reset mid-cycle with entries in flight
    send(64'h8000_0400, 32'h0000_0013, 5'd3, 1'b1, 64'hC3, 1'b0, 64'h0, 1'b0);
    send(64'h8000_0404, 32'h0000_0013, 5'd4, 1'b1, 64'hD4, 1'b0, 64'h0, 1'b0);
    send(64'h8000_0408, 32'h0000_0013, 5'd5, 1'b1, 64'hE5, 1'b0, 64'h0, 1'b0);
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cmtvalid", 64'(o_cmtvalid), 64'd0);
    chk("arst_pc", o_pc, 64'd0);
    chk("arst_wdata", o_rd_wdata, 64'd0);
    chk("arst_instr", o_instr_cnt, 64'd0);
    chk("arst_cycle", o_cycle_cnt, 64'd0);
    chk("arst_ready", 64'(o_wb_ready), 64'd0);
    exp_q.delete();
    exp_instr = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_rel_ready", 64'(o_wb_ready), 64'd1);
    repeat (5) @(negedge clk);
    chk("arst_no_stale", o_instr_cnt, 64'd0);
    chk("arst_cycle_run", o_cycle_cnt, 64'd5);

    // cycle counter wraps modulo 2^64
    force dut.cycle_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.cycle_q;
    chk("wrap_pre", o_cycle_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    chk("wrap_post", o_cycle_cnt, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
